// File: rtl/viterbi_pkg.sv
// Definitions shared by the Viterbi decoder datapath and its output stages.
package viterbi_pkg;

  localparam int unsigned DEC_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } ser_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/dec_byte_serializer.sv
// Buffers decoded bytes and sends each one on a single pad as a start/8-data/stop frame.
module dec_byte_serializer
  import viterbi_pkg::*;
#(
  parameter int unsigned DATA_W  = DEC_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BIT_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      dec_data,
  input  logic                   dec_valid,
  input  logic                   tx_en,
  input  logic                   ovf_clr,
  output logic                   ser_out,
  output logic                   ser_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, pop, drop;

  ser_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_q, ser_d;
  logic              overflow_q;
  logic              div_end, can_start;

  // The decoder cannot stall: a pop in the same cycle makes room for a push into a full FIFO.
  assign push = dec_valid & (~fifo_full | pop);
  assign drop = dec_valid & fifo_full & ~pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (dec_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign div_end   = (div_q == DIV_W'(BIT_DIV - 1));
  assign can_start = tx_en & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        ser_d = STOP_BIT;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          div_d   = '0;
          ser_d   = START_BIT;
          state_d = StStart;
        end
      end
      StStart: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          ser_d   = shift_q[0];
          state_d = StData;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StData: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            ser_d   = STOP_BIT;
            state_d = StStop;
          end else begin
            // LSB first: shift the next bit into position 0.
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            ser_d   = shift_d[0];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StStop: begin
        if (div_end) begin
          div_d = '0;
          if (can_start) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            ser_d   = START_BIT;
            state_d = StStart;
          end else begin
            ser_d   = STOP_BIT;
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        ser_d   = STOP_BIT;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ser_q   <= STOP_BIT;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
    end
  end

  assign ser_out  = ser_q;
  assign ser_busy = (state_q != StIdle);
  assign overflow = overflow_q;

endmodule

// File: doc/dec_byte_serializer.md
Name: dec_byte_serializer

Overview:
- Stage directly downstream of the PipeViterbi decoder core. Consumes its 8-bit decoded output words.
- Buffers words in a small FIFO, then ships each byte out on one serial output pad using UART-style framing.
- Frees seven output pads per chip.
- The decoder cannot stall, so input overflow is flagged rather than back-pressured.

Parameters:
DATA_W, 8, decoded word width (matches decoder data_dec)
DEPTH, 8, FIFO entries; power of 2, >=2
BIT_DIV, 4, clock cycles per serial bit period; >=1

Ports:
clk  input  1  core clock (same clock as decoder)
rst  input  1  reset; asynchronous, active-low
dec_data  input  DATA_W  decoded byte from decoder
dec_valid  input  1  dec_data is valid this cycle
tx_en  input  1  permit starting new frames
ovf_clr  input  1  clears sticky overflow flag
ser_out  output  1  serial line; idles high
ser_busy  output  1  a frame is in progress
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky; a valid input was dropped

Behaviour:
- Reset (rst=0, async, immediate):
  - FIFO pointers and level = 0; overflow = 0.
  - FSM goes to IDLE; ser_out = 1; ser_busy = 0; bit counter and divider counter = 0.
  - This applies mid-frame as well: the in-flight frame and all buffered bytes are discarded. The line returns high the same instant.
- Push: dec_valid=1 and (level<DEPTH, or a pop happens in the same cycle) -> write dec_data at wr_ptr.
  - Push while full with no simultaneous pop -> the byte is dropped and overflow <= 1.
- overflow: sticky. Cleared by ovf_clr=1.
  - ovf_clr and a new drop in the same cycle -> overflow stays 1 (set wins).
- Pointers: wrap modulo DEPTH. Level is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
- FSM states: IDLE, START, DATA, STOP. ser_out is registered.
  - IDLE: ser_out=1, ser_busy=0.
    - If tx_en=1 and level>0: pop the head into shift reg, go to START, ser_out<=0.
    - Reading an empty FIFO is impossible by construction.
  - START: hold 0 for BIT_DIV cycles, then go to DATA with bit_cnt=0 and ser_out<=shift[0].
  - DATA: each bit is held BIT_DIV cycles. Bits go out LSB first.
    - After bit DATA_W-1 completes, go to STOP with ser_out<=1.
  - STOP: hold 1 for BIT_DIV cycles. Then:
    - If tx_en=1 and level>0: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Frame length: (DATA_W+2)*BIT_DIV cycles = 40 cycles at the defaults.
- ser_busy = 1 in START, DATA and STOP.
- Latency: byte pushed at edge N into an empty FIFO with FSM IDLE and tx_en=1:
  - the pop occurs at edge N+1;
  - ser_out falls after edge N+1.
- tx_en=0: no new frame starts. A frame already in progress completes normally. The FIFO keeps accepting pushes.
- Divider counter counts 0..BIT_DIV-1 and resets at every bit boundary. When BIT_DIV=1, each bit lasts exactly one cycle.

Decomposition:
- Shared package viterbi_pkg holds:
  - DEC_W = 8;
  - the serializer state enum (IDLE/START/DATA/STOP);
  - START_BIT = 1'b0 and STOP_BIT = 1'b1.
- One sub-module, sync_fifo (DATA_W, DEPTH):
  - ports: clk, rst, push, pop, wdata, rdata, level, full, empty;
  - rdata shows the head combinationally.
- Overflow logic and the FSM live in dec_byte_serializer.

Test Plan:
1. Reset then single byte (BIT_DIV=1, tx_en=1, push 8'hA5) -> ser_out sequence 0,1,0,1,0,0,1,0,1,1 starting the cycle after the pop; ser_busy high for 10 cycles; level returns to 0.
2. Back-to-back (BIT_DIV=4, push 8'h00 then 8'hFF) -> 80 contiguous busy cycles, no idle-high gap between STOP and the second START; second frame is 4 low, 32 high, 4 high.
3. Overflow (DEPTH=8, tx_en=0, 10 consecutive pushes 1..10) -> level=8, overflow=1. Then tx_en=1: bytes 1..8 are emitted and 9 and 10 are absent. Pulse ovf_clr -> overflow=0.
4. Full with simultaneous pop (fill to 8, tx_en=1, push on the pop cycle) -> push accepted, level stays 8, overflow stays 0.
5. tx_en deasserted mid-frame (byte 8'h3C in DATA, drop tx_en, 2 bytes queued) -> current frame completes, FSM goes to IDLE, ser_out=1, level=2 held until tx_en=1.
6. Async reset mid-frame (rst=0 during DATA bit 3, between clock edges) -> ser_out=1, ser_busy=0, level=0, overflow=0 immediately. After release with no pushes, ser_out stays high.
